// File: rtl/butterfly_r2_scaled_if.sv
// butterfly_r2_scaled_if
//   Sample/result bundle for one radix-2 butterfly stage.
//   master : sample producer (drives xa/xb/w, in_valid, inv, scale, ovf_clr)
//   slave  : butterfly (drives y*, out_valid, ovf, ovf_sticky)
//   All data words are signed two's complement.
interface butterfly_r2_scaled_if #(
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16
);
   logic                       in_valid;
   logic                       inv;
   logic                       scale;
   logic signed [WIDTH-1:0]    xa_real;
   logic signed [WIDTH-1:0]    xa_imag;
   logic signed [WIDTH-1:0]    xb_real;
   logic signed [WIDTH-1:0]    xb_imag;
   logic signed [TW_WIDTH-1:0] w_real;
   logic signed [TW_WIDTH-1:0] w_imag;
   logic                       ovf_clr;

   logic                       out_valid;
   logic signed [WIDTH-1:0]    ya_real;
   logic signed [WIDTH-1:0]    ya_imag;
   logic signed [WIDTH-1:0]    yb_real;
   logic signed [WIDTH-1:0]    yb_imag;
   logic                       ovf;
   logic                       ovf_sticky;

   modport master (
      output in_valid, inv, scale, xa_real, xa_imag, xb_real, xb_imag,
             w_real, w_imag, ovf_clr,
      input  out_valid, ya_real, ya_imag, yb_real, yb_imag, ovf, ovf_sticky
   );

   modport slave (
      input  in_valid, inv, scale, xa_real, xa_imag, xb_real, xb_imag,
             w_real, w_imag, ovf_clr,
      output out_valid, ya_real, ya_imag, yb_real, yb_imag, ovf, ovf_sticky
   );
endinterface

// File: rtl/butterfly_r2_scaled.sv
// butterfly_r2_scaled
//   Radix-2 DIT butterfly: ya = xa + xb*W, yb = xa - xb*W, with per-sample
//   conjugate twiddle (inv), optional divide-by-2 (scale), round-half-up
//   and saturation. Four pipeline stages, one sample per clock, no
//   backpressure.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : butterfly_r2_scaled_if.slave (samples in, results out,
//                ovf per result, ovf_sticky latched until ovf_clr)
module butterfly_r2_scaled #(
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16,
   parameter int TW_FRAC  = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   butterfly_r2_scaled_if.slave bus
);

   localparam int PROD_W = WIDTH + TW_WIDTH;
   localparam int SUM_W  = PROD_W + 1;
   localparam int ACC_W  = PROD_W + 2;

   localparam logic signed [ACC_W:0] RND_S0  = (ACC_W+1)'(1) <<< (TW_FRAC - 1);
   localparam logic signed [ACC_W:0] RND_S1  = (ACC_W+1)'(1) <<< TW_FRAC;
   localparam logic signed [ACC_W:0] SAT_MAX = ((ACC_W+1)'(1) <<< (WIDTH - 1)) - (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   // Valid bits of stages 0..2; out_valid is the stage-3 valid bit.
   logic [2:0] v;

   // Stage 0
   logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [ACC_W-1:0]  xa0_r, xa0_i;
   logic                     inv0, sc0;
   // Stage 1
   logic signed [SUM_W-1:0]  pr1, pi1;
   logic signed [ACC_W-1:0]  xa1_r, xa1_i;
   logic                     sc1;
   // Stage 2
   logic signed [ACC_W-1:0]  ar2, ai2, br2, bi2;
   logic                     sc2;
   // Stage 3 combinational results: {saturated, value}
   logic [WIDTH:0]           rs_ar, rs_ai, rs_br, rs_bi;

   // Round half toward +inf at shift TW_FRAC (+1 when scaling), then clamp.
   function automatic logic [WIDTH:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                input logic sc);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] sh;
      logic [WIDTH:0]        res;
      ext = {acc[ACC_W-1], acc};
      if (sc) sh = (ext + RND_S1) >>> (TW_FRAC + 1);
      else    sh = (ext + RND_S0) >>> TW_FRAC;
      if (sh > SAT_MAX)      res = {1'b1, SAT_MAX[WIDTH-1:0]};
      else if (sh < SAT_MIN) res = {1'b1, SAT_MIN[WIDTH-1:0]};
      else                   res = {1'b0, sh[WIDTH-1:0]};
      return res;
   endfunction

   always_comb begin
      rs_ar = round_sat(ar2, sc2);
      rs_ai = round_sat(ai2, sc2);
      rs_br = round_sat(br2, sc2);
      rs_bi = round_sat(bi2, sc2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v              <= '0;
         p_rr           <= '0;
         p_ii           <= '0;
         p_ri           <= '0;
         p_ir           <= '0;
         xa0_r          <= '0;
         xa0_i          <= '0;
         inv0           <= 1'b0;
         sc0            <= 1'b0;
         pr1            <= '0;
         pi1            <= '0;
         xa1_r          <= '0;
         xa1_i          <= '0;
         sc1            <= 1'b0;
         ar2            <= '0;
         ai2            <= '0;
         br2            <= '0;
         bi2            <= '0;
         sc2            <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.ya_real    <= '0;
         bus.ya_imag    <= '0;
         bus.yb_real    <= '0;
         bus.yb_imag    <= '0;
         bus.ovf        <= 1'b0;
         bus.ovf_sticky <= 1'b0;
      end else begin
         v             <= {v[1:0], bus.in_valid};
         bus.out_valid <= v[2];

         if (bus.in_valid) begin
            p_rr  <= PROD_W'(bus.xb_real) * PROD_W'(bus.w_real);
            p_ii  <= PROD_W'(bus.xb_imag) * PROD_W'(bus.w_imag);
            p_ri  <= PROD_W'(bus.xb_real) * PROD_W'(bus.w_imag);
            p_ir  <= PROD_W'(bus.xb_imag) * PROD_W'(bus.w_real);
            xa0_r <= ACC_W'(bus.xa_real) <<< TW_FRAC;
            xa0_i <= ACC_W'(bus.xa_imag) <<< TW_FRAC;
            inv0  <= bus.inv;
            sc0   <= bus.scale;
         end

         // Conjugation is applied by flipping the sign of the cross terms,
         // so the twiddle itself is never negated.
         if (v[0]) begin
            if (inv0) begin
               pr1 <= SUM_W'(p_rr) + SUM_W'(p_ii);
               pi1 <= SUM_W'(p_ir) - SUM_W'(p_ri);
            end else begin
               pr1 <= SUM_W'(p_rr) - SUM_W'(p_ii);
               pi1 <= SUM_W'(p_ir) + SUM_W'(p_ri);
            end
            xa1_r <= xa0_r;
            xa1_i <= xa0_i;
            sc1   <= sc0;
         end

         if (v[1]) begin
            ar2 <= xa1_r + ACC_W'(pr1);
            ai2 <= xa1_i + ACC_W'(pi1);
            br2 <= xa1_r - ACC_W'(pr1);
            bi2 <= xa1_i - ACC_W'(pi1);
            sc2 <= sc1;
         end

         if (v[2]) begin
            bus.ya_real <= rs_ar[WIDTH-1:0];
            bus.ya_imag <= rs_ai[WIDTH-1:0];
            bus.yb_real <= rs_br[WIDTH-1:0];
            bus.yb_imag <= rs_bi[WIDTH-1:0];
         end
         bus.ovf <= v[2] & (rs_ar[WIDTH] | rs_ai[WIDTH] | rs_br[WIDTH] | rs_bi[WIDTH]);

         // Set has priority over clear.
         if (bus.out_valid && bus.ovf) bus.ovf_sticky <= 1'b1;
         else if (bus.ovf_clr)         bus.ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_butterfly_r2_scaled.sv
module tb_butterfly_r2_scaled;

   localparam int WIDTH    = 16;
   localparam int TW_WIDTH = 16;
   localparam int TW_FRAC  = 14;

   typedef struct packed {
      logic signed [WIDTH-1:0] ar;
      logic signed [WIDTH-1:0] ai;
      logic signed [WIDTH-1:0] br;
      logic signed [WIDTH-1:0] bi;
      logic                    ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   butterfly_r2_scaled_if #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) bif ();

   butterfly_r2_scaled #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .TW_FRAC(TW_FRAC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // ---------------- reference model ----------------
   function automatic longint floordiv(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint rnd_sat(input longint a, input bit sc, inout bit o);
      longint d, r;
      longint hi, lo;
      hi = (longint'(1) << (WIDTH - 1)) - 1;
      lo = -(longint'(1) << (WIDTH - 1));
      d  = longint'(1) << (TW_FRAC + (sc ? 1 : 0));
      r  = floordiv(a + d / 2, d);
      if (r > hi) begin r = hi; o = 1'b1; end
      if (r < lo) begin r = lo; o = 1'b1; end
      return r;
   endfunction

   function automatic exp_t model(input int xar, xai, xbr, xbi, wr, wi, input bit iv, sc);
      longint pr, pi, one;
      bit     o;
      exp_t   e;
      one = longint'(1) << TW_FRAC;
      if (iv) begin
         pr = longint'(xbr) * wr + longint'(xbi) * wi;
         pi = longint'(xbi) * wr - longint'(xbr) * wi;
      end else begin
         pr = longint'(xbr) * wr - longint'(xbi) * wi;
         pi = longint'(xbi) * wr + longint'(xbr) * wi;
      end
      o    = 1'b0;
      e.ar = WIDTH'(rnd_sat(longint'(xar) * one + pr, sc, o));
      e.ai = WIDTH'(rnd_sat(longint'(xai) * one + pi, sc, o));
      e.br = WIDTH'(rnd_sat(longint'(xar) * one - pr, sc, o));
      e.bi = WIDTH'(rnd_sat(longint'(xai) * one - pi, sc, o));
      e.ovf = o;
      return e;
   endfunction

   function automatic exp_t mk(input int ar, ai, br, bi, input bit o);
      exp_t e;
      e.ar = WIDTH'(ar); e.ai = WIDTH'(ai); e.br = WIDTH'(br); e.bi = WIDTH'(bi);
      e.ovf = o;
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic send(input int xar, xai, xbr, xbi, wr, wi, input bit iv, sc,
                       input bit use_dir, input exp_t dir);
      @(posedge clk); #1;
      rst          = 1'b0;
      bif.ovf_clr  = 1'b0;
      bif.in_valid = 1'b1;
      bif.inv      = iv;
      bif.scale    = sc;
      bif.xa_real  = WIDTH'(xar);
      bif.xa_imag  = WIDTH'(xai);
      bif.xb_real  = WIDTH'(xbr);
      bif.xb_imag  = WIDTH'(xbi);
      bif.w_real   = TW_WIDTH'(wr);
      bif.w_imag   = TW_WIDTH'(wi);
      sb.push_back(use_dir ? dir : model(xar, xai, xbr, xbi, wr, wi, iv, sc));
   endtask

   function automatic int rnd_word();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic send_rand();
      send(rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
   endtask

   task automatic ctl(input bit clr, input bit r);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      bif.ovf_clr  = clr;
      rst          = r;
   endtask

   task automatic idle(input int n);
      repeat (n) ctl(1'b0, 1'b0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit   iv_h[4] = '{0, 0, 0, 0};
   bit   rs_h[4] = '{1, 1, 1, 1};
   exp_t hold    = '0;
   bit   exp_sticky = 1'b0;

   always @(negedge clk) begin
      bit   exp_ov;
      exp_t got, e;
      exp_ov = iv_h[3] & ~(rs_h[3] | rs_h[2] | rs_h[1] | rs_h[0]);
      if (rs_h[0]) hold = '0;
      got = {bif.ya_real, bif.ya_imag, bif.yb_real, bif.yb_imag, bif.ovf};

      n_checks++;
      if (bif.out_valid !== exp_ov) begin
         n_fail++;
         $display("FAIL out_valid @%0t: got %b expected %b", $time, bif.out_valid, exp_ov);
      end

      e = '0;
      if (exp_ov) begin
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty @%0t: output expected but no entry queued", $time);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL result @%0t: got ya=(%0d,%0d) yb=(%0d,%0d) ovf=%b expected ya=(%0d,%0d) yb=(%0d,%0d) ovf=%b",
                        $time, got.ar, got.ai, got.br, got.bi, got.ovf, e.ar, e.ai, e.br, e.bi, e.ovf);
            end
            hold = e;
            hold.ovf = 1'b0;
         end
      end else begin
         n_checks++;
         if (got !== hold) begin
            n_fail++;
            $display("FAIL hold @%0t: got ya=(%0d,%0d) yb=(%0d,%0d) ovf=%b expected ya=(%0d,%0d) yb=(%0d,%0d) ovf=0",
                     $time, got.ar, got.ai, got.br, got.bi, got.ovf, hold.ar, hold.ai, hold.br, hold.bi);
         end
      end

      n_checks++;
      if (bif.ovf_sticky !== exp_sticky) begin
         n_fail++;
         $display("FAIL ovf_sticky @%0t: got %b expected %b", $time, bif.ovf_sticky, exp_sticky);
      end
      if (rst)                    exp_sticky = 1'b0;
      else if (exp_ov && e.ovf)   exp_sticky = 1'b1;
      else if (bif.ovf_clr)       exp_sticky = 1'b0;

      if (rst) sb.delete();
      for (int i = 3; i > 0; i--) begin
         iv_h[i] = iv_h[i-1];
         rs_h[i] = rs_h[i-1];
      end
      iv_h[0] = bif.in_valid;
      rs_h[0] = rst;
   end

   // ---------------- stimulus ----------------
   initial begin
      rst          = 1'b1;
      bif.in_valid = 1'b0;
      bif.inv      = 1'b0;
      bif.scale    = 1'b0;
      bif.ovf_clr  = 1'b0;
      bif.xa_real  = '0; bif.xa_imag = '0;
      bif.xb_real  = '0; bif.xb_imag = '0;
      bif.w_real   = '0; bif.w_imag  = '0;
      repeat (3) ctl(1'b0, 1'b1);
      idle(2);

      // unity twiddle
      send(1000, 0, 500, 0, 16384, 0, 1'b0, 1'b0, 1'b1, mk(1500, 0, 500, 0, 1'b0));
      idle(5);
      // twiddle -j, forward and inverse
      send(0, 0, 0, 100, 0, -16384, 1'b0, 1'b0, 1'b1, mk(100, 0, -100, 0, 1'b0));
      send(0, 0, 0, 100, 0, -16384, 1'b1, 1'b0, 1'b1, mk(-100, 0, 100, 0, 1'b0));
      idle(3);
      // saturation, then the same vector scaled
      send(30000, 0, 30000, 0, 16384, 0, 1'b0, 1'b0, 1'b1, mk(32767, 0, 0, 0, 1'b1));
      send(30000, 0, 30000, 0, 16384, 0, 1'b0, 1'b1, 1'b1, mk(30000, 0, 0, 0, 1'b0));
      idle(2);
      // rounding with scale
      send(3, -3, 0, 0, 16384, 0, 1'b0, 1'b1, 1'b1, mk(2, -1, 2, -1, 1'b0));
      idle(1);
      send(1, -1, 0, 0, 16384, 0, 1'b0, 1'b1, 1'b1, mk(1, 0, 1, 0, 1'b0));
      idle(6);

      // streaming: 8 back-to-back, 3 idle, 2 more
      repeat (8) send_rand();
      idle(3);
      repeat (2) send_rand();
      idle(6);

      // random gaps (isolated, alternating, bursts)
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) != 0) send_rand();
         else                           idle(1);
      end
      idle(6);

      // reset with three samples in flight
      repeat (3) send_rand();
      ctl(1'b0, 1'b1);
      idle(6);
      send_rand();
      idle(6);

      // ovf_clr alone, then ovf_clr coincident with a new overflow
      send(30000, 0, 30000, 0, 16384, 0, 1'b0, 1'b0, 1'b1, mk(32767, 0, 0, 0, 1'b1));
      idle(6);
      ctl(1'b1, 1'b0);
      idle(2);
      send(-30000, 0, 30000, 0, 16384, 0, 1'b1, 1'b0, 1'b1, mk(0, 0, -32768, 0, 1'b1));
      idle(3);
      ctl(1'b1, 1'b0);
      idle(3);
      ctl(1'b1, 1'b0);
      idle(3);

      // drain with a bounded wait
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, expected 0", sb.size());
      end
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/butterfly_r2_scaled.md
Name: butterfly_r2_scaled

Overview:
Parametrised radix-2 DIT butterfly for the FFT datapath. It computes ya = xa + xb·W and yb = xa − xb·W in full precision. The block adds four things: a per-sample inverse (conjugate-twiddle) mode, an optional per-sample divide-by-2 stage scaling, round-half-up, and saturation with overflow reporting. It is fully pipelined at one butterfly per clock and is instantiated once per FFT/IFFT stage.

Parameters:
WIDTH, 16, data word width (signed two's complement, all four data inputs and outputs)
TW_WIDTH, 16, twiddle word width (signed)
TW_FRAC, 14, fractional bits of twiddle (W = 1.0 encoded as 2^TW_FRAC)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample qualifier
inv  in  1  1 = use conj(W) (IFFT); sampled with in_valid
scale  in  1  1 = divide both outputs by 2; sampled with in_valid
xa_real, xa_imag  in  WIDTH  signed input A
xb_real, xb_imag  in  WIDTH  signed input B
w_real, w_imag  in  TW_WIDTH  signed twiddle
ovf_clr  in  1  clears ovf_sticky
out_valid  out  1  output qualifier
ya_real, ya_imag, yb_real, yb_imag  out  WIDTH  signed results
ovf  out  1  saturation occurred on any of the 4 outputs of the current out_valid sample
ovf_sticky  out  1  latched ovf since last reset/ovf_clr

Behaviour:
- Clock/reset: one clock (clk). rst is synchronous and active-high. On reset, all pipeline registers, out_valid, ovf, ovf_sticky and all y* outputs go to 0.
- Latency: fixed at 4 cycles. A sample accepted with in_valid=1 at edge N appears with out_valid=1 after edge N+4. Throughput is 1 per cycle. There is no backpressure.
- Valid shift register: v[3:0]. Each pipeline stage loads only when its own valid bit is set. Outputs therefore hold the last valid result while out_valid=0. inv and scale travel down the pipe with their sample.
- Stage 0 (in_valid): register 4 products br·wr, bi·wi, br·wi, bi·wr, each WIDTH+TW_WIDTH bits signed. Register xa sign-extended and left-shifted by TW_FRAC. Register inv and scale.
- Stage 1: inv=0 gives pr = br·wr − bi·wi and pi = bi·wr + br·wi. inv=1 gives pr = br·wr + bi·wi and pi = bi·wr − br·wi. The twiddle is never negated, so −2^(TW_WIDTH−1) is safe. The xa delay aligns both real and imag paths in the same stage.
- Stage 2: ACC_W = WIDTH+TW_WIDTH+2 bits. Compute ar = xa_r + pr, ai = xa_i + pi, br' = xa_r − pr, bi' = xa_i − pi. No truncation is applied here.
- Stage 3: shift S = TW_FRAC + scale. Each result = (acc + 2^(S−1)) >>> S, arithmetic (round half toward +inf). The result then saturates to the range [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- ovf = OR of the 4 saturation events, registered with the outputs. It is 0 whenever out_valid=0.
- ovf_sticky: set when out_valid & ovf; cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
- Reset mid-stream: in-flight samples are discarded. out_valid stays 0 until 4 cycles after the first post-reset in_valid.
- Gaps: any in_valid pattern is supported, including back-to-back, isolated, and alternating. The output order and per-sample inv/scale association are preserved.

Test Plan:
1. Unity twiddle: xa=(1000,0), xb=(500,0), w=(16384,0), inv=0, scale=0 -> 4 cycles later ya=(1500,0), yb=(500,0), ovf=0.
2. Twiddle −j: xa=(0,0), xb=(0,100), w=(0,−16384). With inv=0 -> ya=(100,0), yb=(−100,0). Same vector with inv=1 -> ya=(−100,0), yb=(100,0).
3. Saturation: xa=(30000,0), xb=(30000,0), w=(16384,0), scale=0 -> ya=(32767,0), yb=(0,0), ovf=1, ovf_sticky=1 thereafter. Same vector with scale=1 -> ya=(30000,0), ovf=0.
4. Rounding: xb=0, scale=1. xa=(3,−3) -> ya=(2,−1). xa=(1,−1) -> ya=(1,0).
5. Streaming: 8 back-to-back random vectors with mixed inv/scale, then 3 idle cycles, then 2 more -> out_valid pattern is the input pattern delayed by 4, and results match the bit-exact model. Outputs hold during idle cycles.
6. Control edges: assert rst while 3 samples are in flight -> out_valid=0 and outputs=0 next cycle, with no stale outputs afterwards. Assert ovf_clr in the same cycle as a new overflow -> ovf_sticky stays 1. ovf_clr alone -> 0 next cycle.
